// File: rtl/net_pkg.sv
// Shared flit type and width constants for the NIC, the TX rate limiter and the network endpoint.
package net_pkg;

   localparam int unsigned DATA_W  = 64;
   localparam int unsigned KEEP_W  = DATA_W / 8;
   localparam int unsigned CFG_W   = 8;
   localparam int unsigned TOKEN_W = CFG_W + 1;
   localparam int unsigned STAT_W  = 32;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } net_flit_t;

endpackage

// File: rtl/net_token_bucket.sv
// Token bucket: a period counter that triggers refills and a token counter clamped to the
// bucket size, with one token spent per accepted flit.
module net_token_bucket #(
   parameter int unsigned CFG_W   = net_pkg::CFG_W,
   parameter int unsigned TOKEN_W = net_pkg::TOKEN_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [CFG_W-1:0] inc,
   input  logic [CFG_W-1:0] period,
   input  logic [CFG_W-1:0] size,
   input  logic             spend,
   output logic             has_token
);

   localparam int unsigned SUM_W = TOKEN_W + 1;

   logic [CFG_W-1:0]   period_cnt;
   logic [TOKEN_W-1:0] tokens;
   logic [TOKEN_W-1:0] tokens_next;
   logic [SUM_W-1:0]   sum;
   logic               refill;

   // '>=' rather than '==' so a period shrunk below the current count still wraps.
   always_comb begin
      refill      = (period_cnt >= period);
      sum         = SUM_W'(tokens) - SUM_W'(spend) + (refill ? SUM_W'(inc) : '0);
      tokens_next = (sum > SUM_W'(size)) ? TOKEN_W'(size) : sum[TOKEN_W-1:0];
      has_token   = (tokens != '0);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         period_cnt <= '0;
         tokens     <= '0;
      end else begin
         period_cnt <= refill ? '0 : period_cnt + 1'b1;
         tokens     <= tokens_next;
      end
   end

endmodule

// File: rtl/net_tx_rate_limiter.sv
// Token-bucket throttle on the NIC transmit stream: one registered output stage toward the
// network endpoint plus a saturating count of cycles where a flit waited for tokens.
module net_tx_rate_limiter #(
   parameter int unsigned DATA_W  = net_pkg::DATA_W,
   parameter int unsigned KEEP_W  = DATA_W / 8,
   parameter int unsigned CFG_W   = net_pkg::CFG_W,
   parameter int unsigned TOKEN_W = CFG_W + 1,
   parameter int unsigned STAT_W  = net_pkg::STAT_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_bits_data,
   input  logic [KEEP_W-1:0] in_bits_keep,
   input  logic              in_bits_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_bits_data,
   output logic [KEEP_W-1:0] out_bits_keep,
   output logic              out_bits_last,
   input  logic [CFG_W-1:0]  rlimit_inc,
   input  logic [CFG_W-1:0]  rlimit_period,
   input  logic [CFG_W-1:0]  rlimit_size,
   output logic [STAT_W-1:0] throttle_cnt
);

   logic has_token;
   logic accept;

   always_comb begin
      in_ready = has_token & (~out_valid | out_ready);
      accept   = in_valid & in_ready;
   end

   net_token_bucket #(
      .CFG_W   (CFG_W),
      .TOKEN_W (TOKEN_W)
   ) u_bucket (
      .clock     (clock),
      .reset_n   (reset_n),
      .inc       (rlimit_inc),
      .period    (rlimit_period),
      .size      (rlimit_size),
      .spend     (accept),
      .has_token (has_token)
   );

   // Output stage holds its flit while the endpoint stalls; an accept overwrites it only
   // when the slot is free or draining this cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid     <= 1'b0;
         out_bits_data <= '0;
         out_bits_keep <= '0;
         out_bits_last <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         out_bits_data <= in_bits_data;
         out_bits_keep <= in_bits_keep;
         out_bits_last <= in_bits_last;
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         throttle_cnt <= '0;
      end else if (in_valid && !has_token && !(&throttle_cnt)) begin
         throttle_cnt <= throttle_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_net_tx_rate_limiter.sv
// Directed bench for net_tx_rate_limiter: per-cycle comparison against a token-bucket model
// plus hand-computed expectations on delivery timing, ordering and throttle counts.
module tb_net_tx_rate_limiter;
   import net_pkg::*;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [63:0]       in_bits_data = '0;
   logic [7:0]        in_bits_keep = '0;
   logic              in_bits_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [63:0]       out_bits_data;
   logic [7:0]        out_bits_keep;
   logic              out_bits_last;
   logic [7:0]        rlimit_inc = 8'd1;
   logic [7:0]        rlimit_period = 8'd0;
   logic [7:0]        rlimit_size = 8'd8;
   logic [31:0]       throttle_cnt;

   net_tx_rate_limiter #(
      .DATA_W (64),
      .KEEP_W (8),
      .CFG_W  (8),
      .STAT_W (32)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_bits_data  (in_bits_data),
      .in_bits_keep  (in_bits_keep),
      .in_bits_last  (in_bits_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_bits_data (out_bits_data),
      .out_bits_keep (out_bits_keep),
      .out_bits_last (out_bits_last),
      .rlimit_inc    (rlimit_inc),
      .rlimit_period (rlimit_period),
      .rlimit_size   (rlimit_size),
      .throttle_cnt  (throttle_cnt)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int rel_cycle = 0;

   // model state
   int        m_tok = 0;
   int        m_pc = 0;
   longint    m_thr = 0;
   bit        m_ov = 1'b0;
   net_flit_t m_flit = '0;

   // deliveries observed at the DUT output (sample cycle and payload)
   int          dlv_cyc[$];
   logic [63:0] dlv_data[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: refill every (period+1) cycles, spend one token per accepted flit, clamp to size.
   always @(negedge clock) begin
      bit     m_rdy;
      bit     spend;
      bit     refill;
      int     nt;
      cycle++;
      if (!reset_n) begin
         m_tok = 0; m_pc = 0; m_thr = 0; m_ov = 1'b0; m_flit = '0;
      end
      m_rdy = reset_n && (m_tok > 0) && (!m_ov || out_ready);
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("out_data", out_bits_data, m_flit.data);
      check("out_keep", 64'(out_bits_keep), 64'(m_flit.keep));
      check("out_last", 64'(out_bits_last), 64'(m_flit.last));
      check("throttle_cnt", 64'(throttle_cnt), 64'(m_thr));
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      if (reset_n) begin
         if (out_valid && out_ready) begin
            dlv_cyc.push_back(cycle);
            dlv_data.push_back(out_bits_data);
         end
         spend = in_valid && m_rdy;
         if (in_valid && m_tok == 0 && m_thr < 64'hFFFF_FFFF) m_thr++;
         refill = (m_pc >= int'(rlimit_period));
         m_pc   = refill ? 0 : m_pc + 1;
         nt     = m_tok - int'(spend) + (refill ? int'(rlimit_inc) : 0);
         m_tok  = (nt > int'(rlimit_size)) ? int'(rlimit_size) : nt;
         if (spend) begin
            m_ov   = 1'b1;
            m_flit = '{data: in_bits_data, keep: in_bits_keep, last: in_bits_last};
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_flit(input logic [63:0] base, input int seq);
      logic [7:0] k;
      k            = 8'hFF;
      in_bits_data = base + 64'(seq);
      in_bits_keep = k >> (seq % 4);
      in_bits_last = (seq % 4 == 3);
   endtask

   // Hold in_valid for n cycles, advancing the payload on each accept; returns accepts.
   task automatic drive_for(input int n, input logic [63:0] base, output int acc_cnt);
      bit acc;
      acc_cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            acc_cnt++;
            set_flit(base, acc_cnt);
         end
      end
   endtask

   // Stream n flits within a cycle budget; drops in_valid after the last accept.
   task automatic stream(input int n, input int budget, input logic [63:0] base);
      bit acc;
      int seq;
      int used;
      seq  = 0;
      used = 0;
      set_flit(base, 0);
      in_valid = 1'b1;
      while (seq < n && used < budget) begin
         @(negedge clock);
         acc = in_valid && in_ready;
         tick();
         used++;
         if (acc) begin
            seq++;
            if (seq == n) in_valid = 1'b0;
            else set_flit(base, seq);
         end
      end
      in_valid = 1'b0;
      check("stream_budget", 64'(seq), 64'(n));
   endtask

   task automatic reset_and_release();
      tick();
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n   = 1'b1;
      rel_cycle = cycle;
   endtask

   // Scenario 1 shape: inc=1 period=0 size=8, in_valid from reset release, 32 flits.
   task automatic run_full_rate(input logic [63:0] base);
      int s;
      rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd8; out_ready = 1'b1;
      set_flit(base, 0);
      in_valid = 1'b1;
      s = dlv_cyc.size();
      reset_and_release();
      stream(32, 100, base);
      repeat (3) tick();
      check("s1_count", 64'(dlv_cyc.size() - s), 64'd32);
      if (dlv_cyc.size() - s == 32) begin
         // third falling-edge sample after release == two rising edges of latency
         check("s1_first_latency", 64'(dlv_cyc[s] - rel_cycle), 64'd3);
         check("s1_back_to_back", 64'(dlv_cyc[s+31] - dlv_cyc[s]), 64'd31);
         for (int i = 0; i < 32; i++) check("s1_order", dlv_data[s+i], base + 64'(i));
      end
      check("s1_throttle", 64'(throttle_cnt), 64'd1);
   endtask

   initial begin
      int s;
      int n_acc;
      int stable_bad;

      // reset state
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_throttle", 64'(throttle_cnt), 64'd0);
      check("rst_data", out_bits_data, 64'd0);

      // 1: full rate
      run_full_rate(64'h1000);

      // 2: one token per 4 cycles, bucket of 1
      rlimit_inc = 8'd1; rlimit_period = 8'd3; rlimit_size = 8'd1;
      set_flit(64'h2000, 0);
      in_valid = 1'b1;
      s = dlv_cyc.size();
      reset_and_release();
      stream(16, 200, 64'h2000);
      repeat (3) tick();
      check("s2_count", 64'(dlv_cyc.size() - s), 64'd16);
      if (dlv_cyc.size() - s == 16)
         for (int i = 1; i < 16; i++)
            check("s2_spacing", 64'(dlv_cyc[s+i] - dlv_cyc[s+i-1]), 64'd4);
      // 4 blocked cycles before the first token, then 3 per gap
      check("s2_throttle", 64'(throttle_cnt), 64'd49);

      // 3: saturate the bucket, then stream past the burst
      rlimit_inc = 8'd1; rlimit_period = 8'd1; rlimit_size = 8'd8;
      repeat (100) tick();
      s = dlv_cyc.size();
      stream(24, 200, 64'h3000);
      repeat (3) tick();
      check("s3_count", 64'(dlv_cyc.size() - s), 64'd24);
      if (dlv_cyc.size() - s == 24) begin
         check("s3_burst8", 64'(dlv_cyc[s+7] - dlv_cyc[s]), 64'd7);
         check("s3_paced", 64'(dlv_cyc[s+23] - dlv_cyc[s+22]), 64'd2);
         check("s3_last_data", dlv_data[s+23], 64'h3000 + 64'd23);
      end

      // 4: endpoint stall with a flit held at the input
      rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd8;
      repeat (10) tick();
      out_ready    = 1'b0;
      in_bits_data = 64'h0000_0000_DEAD_BEEF;
      in_bits_keep = 8'h0F;
      in_bits_last = 1'b1;
      in_valid     = 1'b1;
      s = dlv_cyc.size();
      tick();
      stable_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (!(out_valid && !in_ready && out_bits_data == 64'hDEAD_BEEF &&
               out_bits_keep == 8'h0F && out_bits_last)) stable_bad++;
         tick();
      end
      check("s4_stall_stable", 64'(stable_bad), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      check("s4_delivered_once", 64'(dlv_cyc.size() - s), 64'd1);
      if (dlv_cyc.size() - s == 1) check("s4_data", dlv_data[s], 64'hDEAD_BEEF);
      check("s4_out_cleared", 64'(out_valid), 64'd0);

      // 5: full bucket, shrink size to 2 with no refill -> burst of exactly 2
      repeat (20) tick();
      rlimit_size = 8'd2;
      rlimit_inc  = 8'd0;
      tick();
      s = dlv_cyc.size();
      set_flit(64'h5000, 0);
      in_valid = 1'b1;
      drive_for(20, 64'h5000, n_acc);
      in_valid = 1'b0;
      repeat (3) tick();
      check("s5_burst", 64'(n_acc), 64'd2);
      check("s5_delivered", 64'(dlv_cyc.size() - s), 64'd2);

      // size=0 blocks the stream even with refills
      rlimit_size = 8'd0;
      rlimit_inc  = 8'd1;
      repeat (3) tick();
      in_valid = 1'b1;
      drive_for(10, 64'h5100, n_acc);
      in_valid = 1'b0;
      check("s5_size0_blocked", 64'(n_acc), 64'd0);

      // 6: reset mid-packet, then full rate again
      rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd8;
      repeat (10) tick();
      set_flit(64'h6000, 0);
      in_valid = 1'b1;
      drive_for(6, 64'h6000, n_acc);
      check("s6_pre_out_valid", 64'(out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      check("s6_rst_out_valid", 64'(out_valid), 64'd0);
      check("s6_rst_throttle", 64'(throttle_cnt), 64'd0);
      check("s6_rst_in_ready", 64'(in_ready), 64'd0);
      tick();
      run_full_rate(64'h7000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
